// File: rtl/constants_pkg.sv
// Shared constants for the fetch engine and matvec_core.
// Burst lengths and the core state encoding live here so both sides agree.
package constants_pkg;

  localparam int MAT_N      = 4;
  localparam int W_DEPTH    = MAT_N * MAT_N;
  localparam int X_DEPTH    = MAT_N;
  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_LOAD_W,
    ST_LOAD_X,
    ST_COMPUTE,
    ST_OUTPUT
  } core_state_t;

endpackage

// File: rtl/matvec_core_mac.sv
// Registered signed multiply-accumulate with clear and enable.
// The combinational next sum is exported so the caller can capture it early.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 18
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [ACC_WIDTH-1:0]  sum
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;
  // Signed cast sign-extends the product; the add wraps at ACC_WIDTH.
  assign sum  = acc + ACC_WIDTH'(prod);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matvec_core.sv
// Loads an NxN weight matrix and an N-vector from the source stream,
// then emits y = W*x one row at a time on a valid/ready result stream.
module matvec_core
  import constants_pkg::*;
#(
  parameter int N          = MAT_N,
  parameter int DATA_WIDTH = constants_pkg::DATA_WIDTH,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  src_vld,
  output logic                  src_rdy,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  res_vld,
  input  logic                  res_rdy,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_last,
  output logic                  busy
);

  localparam int CW = $clog2(N * N);
  localparam int RW = $clog2(N);
  localparam logic [CW-1:0] W_LAST = CW'(N * N - 1);
  localparam logic [CW-1:0] X_LAST = CW'(N - 1);
  localparam logic [RW-1:0] I_LAST = RW'(N - 1);

  core_state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic [RW-1:0] row, col;
  logic [CW-1:0] widx;
  logic signed [DATA_WIDTH-1:0] w_mem [N*N];
  logic signed [DATA_WIDTH-1:0] x_mem [N];
  logic signed [ACC_WIDTH-1:0] acc, sum;

  logic beat, res_hs, w_done, x_done, row_end;
  logic mac_clr, mac_en;

  assign beat    = src_vld && src_rdy;
  assign res_hs  = res_vld && res_rdy;
  assign w_done  = beat && (cnt == W_LAST);
  assign x_done  = beat && (cnt == X_LAST);
  assign row_end = (col == I_LAST);
  assign widx    = CW'(row) * CW'(N) + CW'(col);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_LOAD_W;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_LOAD_W:  if (w_done)  state_nxt = ST_LOAD_X;
      ST_LOAD_X:  if (x_done)  state_nxt = ST_COMPUTE;
      ST_COMPUTE: if (row_end) state_nxt = ST_OUTPUT;
      ST_OUTPUT:
        if (res_hs)
          state_nxt = (row == I_LAST) ? ST_LOAD_W : ST_COMPUTE;
      default:    state_nxt = ST_LOAD_W;
    endcase
  end

  always_comb begin
    src_rdy = (state == ST_LOAD_W) || (state == ST_LOAD_X);
    busy    = (state == ST_COMPUTE) || (state == ST_OUTPUT);
    mac_en  = (state == ST_COMPUTE);
    mac_clr = ((state == ST_LOAD_X) && x_done)
           || ((state == ST_OUTPUT) && res_hs);
  end

  // Operand storage carries no reset; contents are rewritten every run.
  always_ff @(posedge clk) begin
    if (beat && state == ST_LOAD_W) w_mem[cnt] <= src_data;
    if (beat && state == ST_LOAD_X) x_mem[cnt[RW-1:0]] <= src_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      row      <= '0;
      col      <= '0;
      res_vld  <= 1'b0;
      res_last <= 1'b0;
      res_data <= '0;
    end else begin
      unique case (state)
        ST_LOAD_W: begin
          if (beat) cnt <= w_done ? '0 : cnt + 1'b1;
        end
        ST_LOAD_X: begin
          if (beat) cnt <= x_done ? '0 : cnt + 1'b1;
          if (x_done) begin
            row <= '0;
            col <= '0;
          end
        end
        ST_COMPUTE: begin
          if (row_end) begin
            res_data <= sum;
            res_vld  <= 1'b1;
            res_last <= (row == I_LAST);
          end else begin
            col <= col + 1'b1;
          end
        end
        ST_OUTPUT: begin
          if (res_hs) begin
            res_vld  <= 1'b0;
            res_last <= 1'b0;
            if (row != I_LAST) begin
              row <= row + 1'b1;
              col <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (w_mem[widx]),
    .b    (x_mem[col]),
    .acc  (acc),
    .sum  (sum)
  );

endmodule

// File: tb/tb_matvec_core.sv
// Scoreboard bench for matvec_core; a second instance with a
// 16-bit accumulator runs in lockstep to exercise wrap-around.
module tb_matvec_core;

  localparam int N  = 4;
  localparam int AW = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        src_vld = 1'b0;
  logic [7:0]  src_data = '0;
  logic        res_rdy = 1'b1;
  logic        src_rdy, res_vld, res_last, busy;
  logic [AW-1:0] res_data;
  logic        src_rdy16, res_vld16, res_last16, busy16;
  logic [15:0] res_data16;

  matvec_core dut (
    .clk(clk), .rst_n(rst_n),
    .src_vld(src_vld), .src_rdy(src_rdy), .src_data(src_data),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_data(res_data),
    .res_last(res_last), .busy(busy)
  );

  matvec_core #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .src_vld(src_vld), .src_rdy(src_rdy16), .src_data(src_data),
    .res_vld(res_vld16), .res_rdy(res_rdy), .res_data(res_data16),
    .res_last(res_last16), .busy(busy16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] q[$];
  logic [15:0]   q16[$];
  logic          ql[$];

  logic signed [7:0] tw [16];
  logic signed [7:0] tx [4];

  int gap_max    = 0;
  bit stall_mode = 0;
  int t_last     = -1;
  int hs_run     = 0;

  task automatic send(input logic [7:0] d, input bit is_last_x);
    int t;
    if (gap_max > 0)
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
    src_vld  = 1'b1;
    src_data = d;
    t = 0;
    @(negedge clk);
    while (!src_rdy && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("src_accept", src_rdy, 1);
    if (is_last_x) t_last = cyc;
    @(posedge clk); #1;
    src_vld = 1'b0;
  endtask

  task automatic run();
    longint s;
    for (int r = 0; r < N; r++) begin
      s = 0;
      for (int c = 0; c < N; c++)
        s += longint'(tw[r*N+c]) * longint'(tx[c]);
      q.push_back(AW'(s));
      q16.push_back(16'(s));
      ql.push_back(r == N - 1);
    end
    for (int i = 0; i < N * N; i++) send(tw[i], 1'b0);
    for (int i = 0; i < N; i++) send(tx[i], i == N - 1);
  endtask

  task automatic rand_operands();
    for (int i = 0; i < N * N; i++) tw[i] = 8'($urandom);
    for (int i = 0; i < N; i++) tx[i] = 8'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Result-side ready: optional 5-cycle stall on a random subset of results.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(posedge clk); #1;
      if (!stall_mode) res_rdy = 1'b1;
      else if (res_vld) begin
        if (hold > 0) begin
          res_rdy = 1'b0;
          hold--;
        end else res_rdy = 1'b1;
      end else begin
        hold = ($urandom_range(0, 1) == 1) ? 5 : 0;
        res_rdy = 1'($urandom_range(0, 1));
      end
    end
  end

  // Result monitor and stream-protocol checks.
  initial begin
    bit prev_vld, prev_rdy, prev_last, chk_idle, el;
    logic [AW-1:0] prev_data;
    prev_vld = 0; prev_rdy = 0; prev_last = 0; chk_idle = 0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 0;
        chk_idle = 0;
      end else begin
        if (chk_idle) begin
          chk("next_run_rdy", src_rdy, 1);
          chk("idle_busy", busy, 0);
          chk_idle = 0;
        end
        if (prev_vld && !prev_rdy) begin
          chk("stall_vld", res_vld, 1);
          chk("stall_data", res_data, prev_data);
          chk("stall_last", res_last, prev_last);
        end
        if (busy) chk("rdy_in_busy", src_rdy, 0);
        if (res_vld) chk("busy_out", busy, 1);
        if (res_vld && !prev_vld && hs_run == 0)
          chk("latency", cyc - t_last, N + 1);
        if (res_vld && res_rdy) begin
          chk("q_nonempty", q.size() != 0, 1);
          if (q.size() != 0) begin
            el = ql.pop_front();
            chk("res_data", res_data, q.pop_front());
            chk("res_data16", res_data16, q16.pop_front());
            chk("res_last", res_last, el);
            chk("lock_vld16", res_vld16, 1);
            chk("lock_last16", res_last16, el);
            chk("lock_busy16", busy16, busy);
            hs_run++;
            if (el) begin
              hs_run = 0;
              chk_idle = 1;
            end
          end
        end
        prev_vld  = res_vld;
        prev_rdy  = res_rdy;
        prev_data = res_data;
        prev_last = res_last;
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_res_last", res_last, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src_rdy", src_rdy, 1);
    chk("rst_src_rdy16", src_rdy16, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) tw[i] = (i % 5 == 0) ? 8'sd1 : 8'sd0;
    for (int i = 0; i < 4; i++) tx[i] = 8'(i + 1);
    run();

    for (int i = 0; i < 16; i++) tw[i] = -8'sd1;
    for (int i = 0; i < 4; i++) tx[i] = 8'sd2;
    run();

    rand_operands();
    for (int i = 0; i < 4; i++) tw[i] = 8'sd127;
    for (int i = 0; i < 4; i++) tx[i] = -8'sd128;
    run();

    for (int i = 0; i < 16; i++) tw[i] = 8'sd127;
    for (int i = 0; i < 4; i++) tx[i] = 8'sd127;
    run();
    drain();

    gap_max = 3;
    stall_mode = 1;
    repeat (3) begin
      rand_operands();
      run();
    end
    drain();

    // Abort during row 2 of a run, then start clean.
    gap_max = 0;
    stall_mode = 0;
    rand_operands();
    run();
    t = 0;
    do begin
      @(posedge clk);
      t++;
    end while (hs_run != 2 && t < 500);
    chk("reach_row2", hs_run, 2);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_vld", res_vld, 0);
    chk("abort_busy", busy, 0);
    chk("abort_src_rdy", src_rdy, 1);
    q.delete();
    q16.delete();
    ql.delete();
    hs_run = 0;
    @(posedge clk); #1;

    rand_operands();
    run();
    drain();

    rand_operands();
    run();
    rand_operands();
    run();
    drain();

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
